// File: rtl/hova_frame_pkg.sv
// -----------------------------------------------------------------------------
// hova_frame_pkg
// Shared constants and types for the Hovalaag frame receiver.
//   NUM_STAGES        frame length in slow_clk periods
//   CHUNK_W           width of one host instruction chunk
//   INSTR_W           width of the reassembled instruction
//   PC_STAGE          stage during which the return bus carries pc_next
//   OUT_STAGE         stage during which the return bus carries out_val
//   LAST_CHUNK_STAGE  stage whose capture completes the instruction
//   TAIL_W            instruction bits carried by the last chunk
//   GLITCH_MIN        minimum legal slow_clk high/low time in clk12MHz cycles
// -----------------------------------------------------------------------------
package hova_frame_pkg;

   localparam int NUM_STAGES       = 10;
   localparam int CHUNK_W          = 6;
   localparam int INSTR_W          = 32;
   localparam int PC_STAGE         = 7;
   localparam int OUT_STAGE        = 0;
   localparam int LAST_CHUNK_STAGE = 5;
   localparam int TAIL_W           = INSTR_W - LAST_CHUNK_STAGE * CHUNK_W;
   localparam int BUS_W            = 8;
   localparam int GLITCH_MIN       = 4;

   typedef logic [3:0] stage_t;

   // Frame stage successor: wraps from n-1 back to 0, like the host sequencer.
   function automatic stage_t stage_inc(input stage_t s, input int n);
      return (s == stage_t'(n - 1)) ? stage_t'(0) : s + stage_t'(1);
   endfunction

endpackage

// File: rtl/hova_frame_if.sv
// -----------------------------------------------------------------------------
// hova_frame_if
// Bundles the frame pins from the host, the core-side return values and the
// receiver's results.
//   master : host/core side  (drives slow_clk, host_rst_n, chunk_in,
//                             pc_next, out_val; observes the results)
//   slave  : hova_frame_rx   (drives instr, instr_valid, stage, bus_out
//                             and, with HOVA_FRAME_CHECK_EN, frame_err)
// Optional macro: HOVA_FRAME_CHECK_EN adds the frame_err signal.
// -----------------------------------------------------------------------------
interface hova_frame_if;
   import hova_frame_pkg::*;

   logic               slow_clk;
   logic               host_rst_n;
   logic [CHUNK_W-1:0] chunk_in;
   logic [BUS_W-1:0]   pc_next;
   logic [BUS_W-1:0]   out_val;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   stage_t             stage;
   logic [BUS_W-1:0]   bus_out;

`ifdef HOVA_FRAME_CHECK_EN
   logic               frame_err;

   modport master (
      output slow_clk, host_rst_n, chunk_in, pc_next, out_val,
      input  instr, instr_valid, stage, bus_out, frame_err
   );
   modport slave (
      input  slow_clk, host_rst_n, chunk_in, pc_next, out_val,
      output instr, instr_valid, stage, bus_out, frame_err
   );
`else
   modport master (
      output slow_clk, host_rst_n, chunk_in, pc_next, out_val,
      input  instr, instr_valid, stage, bus_out
   );
   modport slave (
      input  slow_clk, host_rst_n, chunk_in, pc_next, out_val,
      output instr, instr_valid, stage, bus_out
   );
`endif

endinterface

// File: rtl/hova_sync_edge.sv
// -----------------------------------------------------------------------------
// hova_sync_edge
// Synchronises a bundle of asynchronous inputs through one shared
// SYNC_STAGES-deep flop chain (so every bit of the bundle is sampled on the
// same clock) and derives rise/fall strobes from bundle bit 0.
//   clk      in   system clock
//   rst      in   asynchronous active-high reset (clears all flops)
//   i_async  in   W-bit asynchronous bundle, bit 0 is the strobe source
//   o_sync   out  synchronised bundle
//   o_rise   out  one-cycle strobe on a 0->1 of synchronised bit 0
//   o_fall   out  one-cycle strobe on a 1->0 of synchronised bit 0
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module hova_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter int W           = 8
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_async,
   output logic [W-1:0] o_sync,
   output logic         o_rise,
   output logic         o_fall
);
   import hova_frame_pkg::*;

   logic [SYNC_STAGES-1:0][W-1:0] r_chain;
   logic                          r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chain <= '0;
         r_prev  <= 1'b0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
         r_prev  <= r_chain[SYNC_STAGES-1][0];
      end
   end

   assign o_sync = r_chain[SYNC_STAGES-1];
   assign o_rise =  o_sync[0] & ~r_prev;
   assign o_fall = ~o_sync[0] &  r_prev;

endmodule

// File: rtl/hova_frame_rx.sv
// -----------------------------------------------------------------------------
// hova_frame_rx
// Target-side endpoint of the Hovalaag staged I/O frame. Oversamples the host
// slow clock, tracks the frame stage, reassembles the 32-bit instruction from
// six chunks and drives the return bus at the stages the host samples it.
//   clk12MHz  in   system clock
//   reset     in   asynchronous active-high reset
//   frm       slave modport of hova_frame_if:
//     slow_clk/host_rst_n/chunk_in   host frame pins (asynchronous)
//     pc_next/out_val                core values returned to the host
//     instr/instr_valid              last complete instruction + update pulse
//     stage                          current frame stage
//     bus_out                        return bus (io_out)
//     frame_err                      sticky protocol error (checker only)
// Optional macro: HOVA_FRAME_CHECK_EN enables the protocol checker and
// frame_err; without it the checker logic is absent.
// -----------------------------------------------------------------------------
module hova_frame_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_STAGES  = hova_frame_pkg::NUM_STAGES,
   parameter int PC_STAGE    = hova_frame_pkg::PC_STAGE,
   parameter int OUT_STAGE   = hova_frame_pkg::OUT_STAGE
)(
   input  logic        clk12MHz,
   input  logic        reset,
   hova_frame_if.slave frm
);
   import hova_frame_pkg::*;

   localparam int BUNDLE_W = CHUNK_W + 2;

   logic [BUNDLE_W-1:0] w_raw;
   logic [BUNDLE_W-1:0] w_sync;
   logic                w_rise;
   logic                w_fall;
   logic                w_host_rst_n;
   logic [CHUNK_W-1:0]  w_chunk;
   stage_t              w_next_stage;
   logic [BUS_W-1:0]    w_bus_next;
   logic                w_unused;

   stage_t              r_stage;
   logic [INSTR_W-1:0]  r_asm;
   logic                r_done;
   logic [INSTR_W-1:0]  r_instr;
   logic                r_instr_valid;
   logic [BUS_W-1:0]    r_bus_out;

   // Chunk and host reset share the slow_clk chain so the data seen with a
   // rise strobe is the data that was on the pins at that same sample.
   assign w_raw = {frm.chunk_in, frm.host_rst_n, frm.slow_clk};

   hova_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .W           (BUNDLE_W)
   ) u_sync_edge (
      .clk     (clk12MHz),
      .rst     (reset),
      .i_async (w_raw),
      .o_sync  (w_sync),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   assign w_host_rst_n = w_sync[1];
   assign w_chunk      = w_sync[BUNDLE_W-1:2];
   assign w_next_stage = stage_inc(r_stage, NUM_STAGES);

   // Level of slow_clk itself is only needed through the strobes.
   assign w_unused = ^{w_fall, w_sync[0]};

   // Return bus value for the stage being entered.
   always_comb begin
      w_bus_next = '0;
      if (w_next_stage == stage_t'(PC_STAGE)) begin
         w_bus_next = frm.pc_next;
      end else if (w_next_stage == stage_t'(OUT_STAGE)) begin
         w_bus_next = frm.out_val;
      end
   end

   always_ff @(posedge clk12MHz or posedge reset) begin
      if (reset) begin
         r_stage       <= '0;
         r_asm         <= '0;
         r_done        <= 1'b0;
         r_instr       <= '0;
         r_instr_valid <= 1'b0;
         r_bus_out     <= '0;
      end else begin
         // Completion is flagged on the last capture; the full word moves to
         // instr one cycle later together with the valid pulse.
         r_instr_valid <= r_done;
         r_done        <= 1'b0;
         if (r_done) begin
            r_instr <= r_asm;
         end

         if (!w_host_rst_n) begin
            // Host reset wins over a coincident rise.
            r_stage <= '0;
            r_asm   <= '0;
         end else if (w_rise) begin
            r_stage   <= w_next_stage;
            r_bus_out <= w_bus_next;
            for (int k = 0; k < LAST_CHUNK_STAGE; k++) begin
               if (r_stage == stage_t'(k)) begin
                  r_asm[k*CHUNK_W +: CHUNK_W] <= w_chunk;
               end
            end
            // The last chunk carries only the top TAIL_W bits.
            if (r_stage == stage_t'(LAST_CHUNK_STAGE)) begin
               r_asm[INSTR_W-1 -: TAIL_W] <= w_chunk[TAIL_W-1:0];
               r_done                     <= 1'b1;
            end
         end
      end
   end

   assign frm.instr       = r_instr;
   assign frm.instr_valid = r_instr_valid;
   assign frm.stage       = r_stage;
   assign frm.bus_out     = r_bus_out;

`ifdef HOVA_FRAME_CHECK_EN
   logic       r_frame_err;
   logic [2:0] r_lvl_cnt;
   logic       r_armed;

   // r_lvl_cnt holds how many cycles synced slow_clk has kept its current
   // level (saturating). The first edge after reset only arms the check,
   // since the level before it has no known start.
   always_ff @(posedge clk12MHz or posedge reset) begin
      if (reset) begin
         r_frame_err <= 1'b0;
         r_lvl_cnt   <= '0;
         r_armed     <= 1'b0;
      end else begin
         if (w_rise || w_fall) begin
            r_lvl_cnt <= 3'd1;
            r_armed   <= 1'b1;
            if (r_armed && (r_lvl_cnt < 3'(GLITCH_MIN))) begin
               r_frame_err <= 1'b1;
            end
         end else if (r_lvl_cnt != 3'd7) begin
            r_lvl_cnt <= r_lvl_cnt + 3'd1;
         end

         if (w_host_rst_n && w_rise) begin
            if ((r_stage == stage_t'(LAST_CHUNK_STAGE)) &&
                (w_chunk[CHUNK_W-1:TAIL_W] != '0)) begin
               r_frame_err <= 1'b1;
            end
            if ((r_stage > stage_t'(LAST_CHUNK_STAGE)) && (w_chunk != '0)) begin
               r_frame_err <= 1'b1;
            end
         end
      end
   end

   assign frm.frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_hova_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_hova_frame_rx
// Drives host frames (random slow_clk phase lengths, random instructions,
// occasional host-reset aborts) and checks the receiver against a frame-level
// reference model through two scoreboards: completed instructions and
// mid-stage samples of stage/bus_out/instr (taken where the host samples).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hova_frame_rx;
   import hova_frame_pkg::*;

   logic clk12MHz = 1'b0;
   logic reset;

   hova_frame_if frm ();

   hova_frame_rx dut (
      .clk12MHz (clk12MHz),
      .reset    (reset),
      .frm      (frm)
   );

   always #42 clk12MHz = ~clk12MHz;

   typedef struct {
      logic [31:0] instr;
      int          rise_idx;
   } instr_exp_t;

   typedef struct {
      int          stg;
      logic [7:0]  bus;
      bit          bus_known;
      logic [31:0] instr;
      bit          err;
   } mid_exp_t;

   instr_exp_t  q_instr[$];
   mid_exp_t    q_mid[$];

   int          n_vec = 0;
   int          n_err = 0;

   // reference model of the host frame as seen by the receiver
   int          mdl_stage;
   logic [5:0]  mdl_chunks[6];
   logic [31:0] mdl_instr;
   logic [7:0]  mdl_bus;
   bit          bus_known;
   bit          mdl_err;
   int          rise_cnt;
   bit          rand_bus;
   logic        prev_valid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] junk_hi();
`ifdef HOVA_FRAME_CHECK_EN
      return 4'd0;
`else
      return 4'($urandom);
`endif
   endfunction

   // Rising slow_clk: ends the current stage and applies the frame rules.
   task automatic slow_rise();
      logic [31:0] v;
      frm.slow_clk = 1'b1;
      rise_cnt++;
      if (mdl_stage <= 5) mdl_chunks[mdl_stage] = frm.chunk_in;
      if (mdl_stage == 5 && (frm.chunk_in / 6'd4) != 6'd0) mdl_err = 1'b1;
      if (mdl_stage >= 6 && frm.chunk_in != 6'd0) mdl_err = 1'b1;
      if (mdl_stage == 5) begin
         v = 32'd0;
         for (int k = 0; k < 5; k++) v = v + 32'(mdl_chunks[k]) * (32'd1 << (6 * k));
         v = v + (32'(mdl_chunks[5]) % 32'd4) * 32'h4000_0000;
         mdl_instr = v;
         q_instr.push_back('{v, rise_cnt});
      end
      mdl_stage = (mdl_stage + 1) % NUM_STAGES;
      if (mdl_stage == PC_STAGE)       mdl_bus = frm.pc_next;
      else if (mdl_stage == OUT_STAGE) mdl_bus = frm.out_val;
      else                             mdl_bus = 8'h00;
      bus_known = 1'b1;
   endtask

   // One slow period: (rise,) high phase, fall with new chunk, low phase.
   task automatic stage_cycle(input logic [5:0] ch);
      int h;
      int l;
      h = int'($urandom_range(9, 5));
      l = int'($urandom_range(9, 5));
      if (frm.slow_clk == 1'b0) slow_rise();
      repeat (h) @(negedge clk12MHz);
      q_mid.push_back('{mdl_stage, mdl_bus, bus_known, mdl_instr, mdl_err});
      frm.slow_clk = 1'b0;
      frm.chunk_in = ch;
      if (rand_bus) begin
         frm.pc_next = 8'($urandom);
         frm.out_val = 8'($urandom);
      end
      repeat (l) @(negedge clk12MHz);
   endtask

   task automatic host_reset_seq();
      frm.host_rst_n = 1'b0;
      mdl_stage = 0;
      bus_known = 1'b0;
      repeat (6) @(negedge clk12MHz);
      for (int t = 0; t < 2; t++) begin
         frm.slow_clk = ~frm.slow_clk;
         repeat (6) @(negedge clk12MHz);
      end
      if (frm.slow_clk == 1'b0) begin
         frm.slow_clk = 1'b1;
         repeat (6) @(negedge clk12MHz);
      end
      frm.host_rst_n = 1'b1;
   endtask

   task automatic send_frame(input logic [31:0] w, input int abort_at, input logic [3:0] hi);
      logic [5:0] ch;
      for (int s = 0; s < NUM_STAGES; s++) begin
         if (s < 5)       ch = w[6*s +: 6];
         else if (s == 5) ch = {hi, w[31:30]};
         else             ch = 6'd0;
         stage_cycle(ch);
         if (s == abort_at) begin
            host_reset_seq();
            return;
         end
      end
   endtask

   // monitor: instruction completions
   initial begin
      instr_exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk12MHz);
         if (frm.instr_valid === 1'b1) begin
            check("valid_width", 32'(prev_valid), 32'd0);
            if (q_instr.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL instr_valid_unexpected: got 1 expected 0 at %0t", $time);
            end else begin
               e = q_instr.pop_front();
               check("instr", frm.instr, e.instr);
               check("valid_rise_idx", 32'(rise_cnt), 32'(e.rise_idx));
            end
         end
         prev_valid = frm.instr_valid;
      end
   end

   // monitor: mid-stage samples where the host reads io_out
   initial begin
      mid_exp_t m;
      forever begin
         @(negedge frm.slow_clk);
         if (q_mid.size() > 0) begin
            m = q_mid.pop_front();
            check("stage", 32'(frm.stage), 32'(m.stg));
            if (m.bus_known) check("bus_out", 32'(frm.bus_out), 32'(m.bus));
            check("instr_hold", frm.instr, m.instr);
`ifdef HOVA_FRAME_CHECK_EN
            check("frame_err", 32'(frm.frame_err), 32'(m.err));
`endif
         end
      end
   end

   initial begin
      logic [31:0] w;
      int          ab;
      reset          = 1'b1;
      frm.slow_clk   = 1'b0;
      frm.host_rst_n = 1'b0;
      frm.chunk_in   = 6'd0;
      frm.pc_next    = 8'h05;
      frm.out_val    = 8'hA3;
      mdl_stage      = 0;
      mdl_instr      = 32'd0;
      mdl_bus        = 8'h00;
      bus_known      = 1'b0;
      mdl_err        = 1'b0;
      rise_cnt       = 0;
      rand_bus       = 1'b0;
      for (int k = 0; k < 6; k++) mdl_chunks[k] = 6'd0;

      // reset held with slow_clk toggling
      repeat (3) begin
         @(negedge clk12MHz);
         frm.slow_clk = ~frm.slow_clk;
         check("rst_instr", frm.instr, 32'd0);
         check("rst_valid", 32'(frm.instr_valid), 32'd0);
         check("rst_stage", 32'(frm.stage), 32'd0);
         check("rst_bus", 32'(frm.bus_out), 32'd0);
`ifdef HOVA_FRAME_CHECK_EN
         check("rst_frame_err", 32'(frm.frame_err), 32'd0);
`endif
      end
      @(negedge clk12MHz);
      reset = 1'b0;
      repeat (8) @(negedge clk12MHz);
      check("hostrst_stage", 32'(frm.stage), 32'd0);
      check("hostrst_instr", frm.instr, 32'd0);
      check("hostrst_bus", 32'(frm.bus_out), 32'd0);
      frm.host_rst_n = 1'b1;
      repeat (4) @(negedge clk12MHz);

      send_frame(32'h0000_0040, -1, junk_hi());
      send_frame(32'hDEAD_BEEF, 3, junk_hi());      // abandoned in stage 3
      send_frame(32'h0BAD_F00D, -1, junk_hi());
      send_frame(32'hFFFF_FFFF, -1, junk_hi());
      send_frame(32'h1234_5678, -1, junk_hi());

      rand_bus = 1'b1;
      repeat (14) begin
         w  = $urandom;
         ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(9, 0)) : -1;
         send_frame(w, ab, junk_hi());
      end

`ifdef HOVA_FRAME_CHECK_EN
      send_frame(32'h2ABC_DEF1, -1, 4'hF);          // stage-5 chunk 6'h3C
      send_frame(32'h0000_1111, -1, 4'h0);
`endif

      repeat (20) @(negedge clk12MHz);
      check("pending_instr", 32'(q_instr.size()), 32'd0);
      check("pending_mid", 32'(q_mid.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
